dram_req_scheduler: RTL and testbench
=====================================

DRAM_REQ_SCHEDULER -- requirements
Module: dram_req_scheduler

Interface
REQ-001 SHALL have parameters: NUM_REQ, 2, requester count (>=2); PADDR_BITS, 19, request address width; ROW_BITS, 8, row bits; COL_BITS, 4, column bits; BANKS, 8, bank count (power of two); ACTIVATION_LATENCY, 8, ACT-to-RD/WR cycles (>=1); PRECHARGE_LATENCY, 5, PRE-to-ACT cycles (>=1); CAS_LATENCY, 22, RD-to-data cycles (>=1).
REQ-002 SHALL have ports: clk_in in 1, the single clock; rst_in in 1, reset, synchronous and active-high.
REQ-003 SHALL have ports: req_valid_in in NUM_REQ, per-requester valid; req_ready_out out NUM_REQ, per-requester accept; req_addr_in in NUM_REQ x PADDR_BITS, address, MSB = write enable; req_wdata_in in NUM_REQ x 64, write data.
REQ-004 SHALL have ports: rsp_valid_out out NUM_REQ, one-cycle read-return pulse; rsp_data_out out 64, read data.
REQ-005 SHALL have ports: cmd_valid_out out 1, command strobe; cmd_out out 3, RD=000 WR=001 ACT=010 PRE=011; cmd_bank_out out log2(BANKS); cmd_row_out out ROW_BITS; cmd_col_out out COL_BITS; wdata_out out 64; rdata_in in 64, DRAM read data; hit_count_out out 16, row-hit count.

Function
REQ-006 SHALL decode addresses as: col = addr[COL_BITS-1:0]; bank = next log2(BANKS) bits; row = next ROW_BITS bits; we = addr[PADDR_BITS-1]; other bits ignored.
REQ-007 SHALL keep a per-bank open flag and open-row register, updated only by its own PRE/ACT commands.
REQ-008 SHALL use FSM states IDLE, DECIDE, ISSUE_PRE, WAIT_PRE, ISSUE_ACT, WAIT_ACT, ISSUE_RW, WAIT_CAS, RESP, and service exactly one request at a time.
REQ-009 SHALL, in IDLE only, drive req_ready_out combinationally high for at most one requester: the first valid index searched round-robin from (last_grant+1) mod NUM_REQ; all ready bits are low in every other state.
REQ-010 SHALL, on valid&ready, latch addr, wdata, and requester id; set last_grant to that id; and enter DECIDE next cycle.
REQ-011 SHALL, in DECIDE, go to ISSUE_RW if the bank is open and the row matches, incrementing hit_count_out and saturating at 16'hFFFF. If open with a different row, go to ISSUE_PRE; if closed, go to ISSUE_ACT.
REQ-012 SHALL, in ISSUE_PRE, pulse cmd_valid_out with PRE and the bank, and clear the bank's open flag; ACT SHALL issue exactly PRECHARGE_LATENCY cycles after PRE.
REQ-013 SHALL, in ISSUE_ACT, pulse ACT with bank and row, set open flag and row; RD/WR SHALL issue exactly ACTIVATION_LATENCY cycles after ACT.
REQ-014 SHALL, in ISSUE_RW, pulse RD or WR with bank and col; for WR, drive wdata_out = latched wdata in that cycle, then go to IDLE with no response.
REQ-015 SHALL, for RD issued at cycle t, sample rdata_in at cycle t+CAS_LATENCY, and pulse rsp_valid_out[id] with rsp_data_out = that sample at t+CAS_LATENCY+1 (RESP), then go to IDLE.
REQ-016 SHALL drive cmd_valid_out low, and cmd/bank/row/col/wdata outputs to 0, in all non-issue states.
REQ-017 SHALL leave requesters that are not granted unaffected; a requester SHALL hold valid and address stable until ready; a dropped valid before grant is not an error.
REQ-018 SHALL give fixed latency from acceptance at cycle 0: hit RD at 2; closed-bank ACT at 2, RD at 2+ACTIVATION_LATENCY; conflict PRE at 2, ACT at 2+PRECHARGE_LATENCY, RD at 2+PRECHARGE_LATENCY+ACTIVATION_LATENCY.

Reset
REQ-019 SHALL, while rst_in is high at a clock edge, enter IDLE and clear all open flags, rows, hit_count_out, and all outputs; set last_grant = NUM_REQ-1 so requester 0 wins first.
REQ-020 SHALL, on reset mid-operation (any state), abort the request with no rsp_valid_out pulse and no further command.

Verification
REQ-021 SHALL test: after reset, req0 read bank0 row3 accepted at cycle 0 -> ACT at 2, RD at 10, rsp_valid_out[0] at 33 with rsp_data_out = rdata_in at 32.
REQ-022 SHALL test: then read same bank/row -> RD at 2, rsp at 25, hit_count_out = 1.
REQ-023 SHALL test: then read bank0 row7 -> PRE at 2, ACT row7 at 7, RD at 15, hit_count_out unchanged.
REQ-024 SHALL test: both valid continuously after reset -> grants 0,1,0,1; never two ready bits high together.
REQ-025 SHALL test: write hit with wdata 64'hDEADBEEF_CAFEF00D -> WR with wdata_out equal in the same cycle, no rsp_valid_out, ready again next cycle.
REQ-026 SHALL test: reset during WAIT_CAS -> no rsp_valid_out; next request to that bank/row issues ACT, not RD.

Source files
------------

// File: rtl/dram_req_scheduler_if.sv
// Requester, response and DRAM command bundle for the request scheduler.
interface dram_req_scheduler_if #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned PADDR_BITS = 19,
  parameter int unsigned ROW_BITS   = 8,
  parameter int unsigned COL_BITS   = 4,
  parameter int unsigned BANKS      = 8
);
  logic [NUM_REQ-1:0]                 req_valid_in;
  logic [NUM_REQ-1:0]                 req_ready_out;
  logic [NUM_REQ-1:0][PADDR_BITS-1:0] req_addr_in;
  logic [NUM_REQ-1:0][63:0]           req_wdata_in;
  logic [NUM_REQ-1:0]                 rsp_valid_out;
  logic [63:0]                        rsp_data_out;
  logic                               cmd_valid_out;
  logic [2:0]                         cmd_out;
  logic [$clog2(BANKS)-1:0]           cmd_bank_out;
  logic [ROW_BITS-1:0]                cmd_row_out;
  logic [COL_BITS-1:0]                cmd_col_out;
  logic [63:0]                        wdata_out;
  logic [63:0]                        rdata_in;
  logic [15:0]                        hit_count_out;

  modport slave (
    input  req_valid_in, req_addr_in, req_wdata_in, rdata_in,
    output req_ready_out, rsp_valid_out, rsp_data_out, cmd_valid_out, cmd_out,
    output cmd_bank_out, cmd_row_out, cmd_col_out, wdata_out, hit_count_out
  );

  modport master (
    output req_valid_in, req_addr_in, req_wdata_in, rdata_in,
    input  req_ready_out, rsp_valid_out, rsp_data_out, cmd_valid_out, cmd_out,
    input  cmd_bank_out, cmd_row_out, cmd_col_out, wdata_out, hit_count_out
  );
endinterface

// File: rtl/dram_req_scheduler.sv
// Single-outstanding DRAM request scheduler: round-robin arbitration, per-bank
// open-row tracking, PRE/ACT/RD/WR sequencing with fixed latencies.
module dram_req_scheduler #(
  parameter int unsigned NUM_REQ            = 2,
  parameter int unsigned PADDR_BITS         = 19,
  parameter int unsigned ROW_BITS           = 8,
  parameter int unsigned COL_BITS           = 4,
  parameter int unsigned BANKS              = 8,
  parameter int unsigned ACTIVATION_LATENCY = 8,
  parameter int unsigned PRECHARGE_LATENCY  = 5,
  parameter int unsigned CAS_LATENCY        = 22
) (
  input logic                 clk_in,
  input logic                 rst_in,
  dram_req_scheduler_if.slave bus
);
  localparam int unsigned BankBits = $clog2(BANKS);
  localparam int unsigned IdBits   = $clog2(NUM_REQ);
  localparam int unsigned MaxLat   =
      (CAS_LATENCY > ACTIVATION_LATENCY) ?
      ((CAS_LATENCY > PRECHARGE_LATENCY) ? CAS_LATENCY : PRECHARGE_LATENCY) :
      ((ACTIVATION_LATENCY > PRECHARGE_LATENCY) ? ACTIVATION_LATENCY : PRECHARGE_LATENCY);
  localparam int unsigned CntW     = $clog2(MaxLat + 1);

  // Wait-state loads: the issue cycle itself counts as the first latency cycle.
  localparam logic [CntW-1:0] PreWait =
      CntW'((PRECHARGE_LATENCY > 1) ? PRECHARGE_LATENCY - 2 : 0);
  localparam logic [CntW-1:0] ActWait =
      CntW'((ACTIVATION_LATENCY > 1) ? ACTIVATION_LATENCY - 2 : 0);
  localparam logic [CntW-1:0] CasWait = CntW'(CAS_LATENCY - 1);

  localparam logic [2:0] CmdRd  = 3'b000;
  localparam logic [2:0] CmdWr  = 3'b001;
  localparam logic [2:0] CmdAct = 3'b010;
  localparam logic [2:0] CmdPre = 3'b011;

  localparam logic [3:0] StIdle     = 4'd0;
  localparam logic [3:0] StDecide   = 4'd1;
  localparam logic [3:0] StIssuePre = 4'd2;
  localparam logic [3:0] StWaitPre  = 4'd3;
  localparam logic [3:0] StIssueAct = 4'd4;
  localparam logic [3:0] StWaitAct  = 4'd5;
  localparam logic [3:0] StIssueRw  = 4'd6;
  localparam logic [3:0] StWaitCas  = 4'd7;
  localparam logic [3:0] StResp     = 4'd8;

  logic [3:0]            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdBits-1:0]     id_q, last_grant_q, grant_id;
  logic                  grant_valid;
  int unsigned           cand;
  logic [PADDR_BITS-1:0] sel_addr;
  logic                  unused_addr;
  logic                  we_q;
  logic [BankBits-1:0]   bank_q;
  logic [ROW_BITS-1:0]   row_q;
  logic [COL_BITS-1:0]   col_q;
  logic [63:0]           wdata_q, rdata_q;
  logic [15:0]           hit_q;
  logic [BANKS-1:0]      open_q;
  logic [ROW_BITS-1:0]   open_row_q [BANKS];
  logic                  row_hit;

  always_comb begin
    grant_valid       = 1'b0;
    grant_id          = '0;
    cand              = 0;
    bus.req_ready_out = '0;
    if (state_q == StIdle && !rst_in) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        cand = (32'(last_grant_q) + i + 1) % NUM_REQ;
        if (!grant_valid && bus.req_valid_in[cand[IdBits-1:0]]) begin
          grant_valid = 1'b1;
          grant_id    = cand[IdBits-1:0];
        end
      end
      if (grant_valid) bus.req_ready_out[grant_id] = 1'b1;
    end
  end

  assign sel_addr    = bus.req_addr_in[grant_id];
  assign unused_addr = ^sel_addr;
  assign row_hit     = open_q[bank_q] && (open_row_q[bank_q] == row_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle:     if (grant_valid) state_d = StDecide;
      StDecide: begin
        if (row_hit)             state_d = StIssueRw;
        else if (open_q[bank_q]) state_d = StIssuePre;
        else                     state_d = StIssueAct;
      end
      StIssuePre: begin
        state_d = (PRECHARGE_LATENCY > 1) ? StWaitPre : StIssueAct;
        cnt_d   = PreWait;
      end
      StWaitPre: begin
        if (cnt_q == '0) state_d = StIssueAct;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StIssueAct: begin
        state_d = (ACTIVATION_LATENCY > 1) ? StWaitAct : StIssueRw;
        cnt_d   = ActWait;
      end
      StWaitAct: begin
        if (cnt_q == '0) state_d = StIssueRw;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StIssueRw: begin
        state_d = we_q ? StIdle : StWaitCas;
        cnt_d   = CasWait;
      end
      StWaitCas: begin
        if (cnt_q == '0) state_d = StResp;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StResp:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      id_q         <= '0;
      last_grant_q <= IdBits'(NUM_REQ - 1);
      we_q         <= 1'b0;
      bank_q       <= '0;
      row_q        <= '0;
      col_q        <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      hit_q        <= '0;
      open_q       <= '0;
      for (int unsigned b = 0; b < BANKS; b++) open_row_q[b] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StIdle && grant_valid) begin
        id_q         <= grant_id;
        last_grant_q <= grant_id;
        we_q         <= sel_addr[PADDR_BITS-1];
        col_q        <= sel_addr[COL_BITS-1:0];
        bank_q       <= sel_addr[COL_BITS +: BankBits];
        row_q        <= sel_addr[COL_BITS+BankBits +: ROW_BITS];
        wdata_q      <= bus.req_wdata_in[grant_id];
      end
      if (state_q == StDecide && row_hit && hit_q != 16'hFFFF) hit_q <= hit_q + 16'd1;
      if (state_q == StIssuePre) open_q[bank_q] <= 1'b0;
      if (state_q == StIssueAct) begin
        open_q[bank_q]     <= 1'b1;
        open_row_q[bank_q] <= row_q;
      end
      if (state_q == StWaitCas && cnt_q == '0) rdata_q <= bus.rdata_in;
    end
  end

  assign bus.hit_count_out = hit_q;

  always_comb begin
    bus.cmd_valid_out = 1'b0;
    bus.cmd_out       = '0;
    bus.cmd_bank_out  = '0;
    bus.cmd_row_out   = '0;
    bus.cmd_col_out   = '0;
    bus.wdata_out     = '0;
    bus.rsp_valid_out = '0;
    bus.rsp_data_out  = '0;
    case (state_q)
      StIssuePre: begin
        bus.cmd_valid_out = 1'b1;
        bus.cmd_out       = CmdPre;
        bus.cmd_bank_out  = bank_q;
      end
      StIssueAct: begin
        bus.cmd_valid_out = 1'b1;
        bus.cmd_out       = CmdAct;
        bus.cmd_bank_out  = bank_q;
        bus.cmd_row_out   = row_q;
      end
      StIssueRw: begin
        bus.cmd_valid_out = 1'b1;
        bus.cmd_out       = we_q ? CmdWr : CmdRd;
        bus.cmd_bank_out  = bank_q;
        bus.cmd_col_out   = col_q;
        bus.wdata_out     = we_q ? wdata_q : '0;
      end
      StResp: begin
        bus.rsp_valid_out[id_q] = 1'b1;
        bus.rsp_data_out        = rdata_q;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_dram_req_scheduler.sv
// Directed bench with an event scoreboard: each accepted request queues its
// expected commands/response with absolute cycles; a negedge monitor pops them.
module tb_dram_req_scheduler;
  localparam int unsigned ActLat = 8;
  localparam int unsigned PreLat = 5;
  localparam int unsigned CasLat = 22;
  localparam int unsigned Banks  = 8;

  typedef struct {
    bit          is_rsp;
    int          cyc;
    logic [2:0]  cmd;
    logic [2:0]  bank;
    logic [7:0]  row;
    logic [3:0]  col;
    logic [63:0] data;
    logic [1:0]  rsp;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  q[$];
  bit   m_open[Banks];
  logic [7:0] m_row[Banks];
  int   m_hits = 0;

  dram_req_scheduler_if bus ();

  dram_req_scheduler dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] pat(int n);
    return {32'(n) ^ 32'h5A5A_0000, 32'(n) * 32'h9E37_79B9};
  endfunction

  assign bus.rdata_in = pat(cyc);

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] build_addr(bit we, logic [2:0] bank, logic [7:0] row,
                                             logic [3:0] col);
    logic [18:0] a;
    a        = '0;
    a[3:0]   = col;
    a[6:4]   = bank;
    a[14:7]  = row;
    a[17:15] = 3'b101;  // ignored bits, deliberately non-zero
    a[18]    = we;
    return a;
  endfunction

  function automatic ev_t mk(bit r, int c, logic [2:0] cmd, logic [2:0] bank,
                             logic [7:0] row, logic [3:0] col, logic [63:0] d,
                             logic [1:0] rsp);
    ev_t e;
    e.is_rsp = r; e.cyc = c; e.cmd = cmd; e.bank = bank;
    e.row = row; e.col = col; e.data = d; e.rsp = rsp;
    return e;
  endfunction

  function automatic void push_req(int id, bit we, logic [2:0] bank, logic [7:0] row,
                                   logic [3:0] col, logic [63:0] wd, int acc);
    int t;
    t = acc + 2;
    if (m_open[bank] && m_row[bank] == row) begin
      if (m_hits < 65535) m_hits++;
    end else begin
      if (m_open[bank]) begin
        q.push_back(mk(0, t, 3'b011, bank, '0, '0, '0, '0));
        t += PreLat;
      end
      q.push_back(mk(0, t, 3'b010, bank, row, '0, '0, '0));
      t += ActLat;
      m_open[bank] = 1'b1;
      m_row[bank]  = row;
    end
    q.push_back(mk(0, t, we ? 3'b001 : 3'b000, bank, '0, col, wd, '0));
    if (!we) q.push_back(mk(1, t + CasLat + 1, '0, '0, '0, '0, pat(t + CasLat), 2'(1 << id)));
  endfunction

  always @(negedge clk) begin
    ev_t e;
    chk("ready_onehot", 64'($countones(bus.req_ready_out) <= 1), 64'd1);
    if (bus.cmd_valid_out) begin
      chk("cmd_expected", 64'(q.size() > 0 && !q[0].is_rsp), 64'd1);
      if (q.size() > 0 && !q[0].is_rsp) begin
        e = q.pop_front();
        chk("cmd_cycle", 64'(cyc), 64'(e.cyc));
        chk("cmd_code", 64'(bus.cmd_out), 64'(e.cmd));
        chk("cmd_bank", 64'(bus.cmd_bank_out), 64'(e.bank));
        if (e.cmd == 3'b010) chk("cmd_row", 64'(bus.cmd_row_out), 64'(e.row));
        if (e.cmd[2:1] == 2'b00) chk("cmd_col", 64'(bus.cmd_col_out), 64'(e.col));
        if (e.cmd == 3'b001) chk("cmd_wdata", bus.wdata_out, e.data);
      end
    end else begin
      chk("cmd_idle_zero", 64'(|{bus.cmd_out, bus.cmd_bank_out, bus.cmd_row_out,
                                 bus.cmd_col_out, bus.wdata_out}), 64'd0);
    end
    if (|bus.rsp_valid_out) begin
      chk("rsp_expected", 64'(q.size() > 0 && q[0].is_rsp), 64'd1);
      if (q.size() > 0 && q[0].is_rsp) begin
        e = q.pop_front();
        chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
        chk("rsp_id", 64'(bus.rsp_valid_out), 64'(e.rsp));
        chk("rsp_data", bus.rsp_data_out, e.data);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid_in = '0;
    for (int b = 0; b < Banks; b++) begin
      m_open[b] = 1'b0;
      m_row[b]  = '0;
    end
    m_hits = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_hit", 64'(bus.hit_count_out), 64'd0);
    chk("rst_cmd_valid", 64'(bus.cmd_valid_out), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid_out), 64'd0);
    chk("rst_ready", 64'(bus.req_ready_out), 64'd0);
  endtask

  task automatic do_req(int id, bit we, logic [2:0] bank, logic [7:0] row, logic [3:0] col,
                        logic [63:0] wd, output int acc);
    bit got;
    got = 1'b0;
    acc = 0;
    @(negedge clk);
    bus.req_valid_in[id] = 1'b1;
    bus.req_addr_in[id]  = build_addr(we, bank, row, col);
    bus.req_wdata_in[id] = wd;
    for (int k = 0; k < 200 && !got; k++) begin
      #1;
      if (bus.req_ready_out[id]) begin
        got = 1'b1;
        acc = cyc;
        push_req(id, we, bank, row, col, wd, acc);
      end else begin
        @(negedge clk);
      end
    end
    chk("grant_seen", 64'(got), 64'd1);
    @(posedge clk);
    #1 bus.req_valid_in[id] = 1'b0;
  endtask

  task automatic drain(int bound);
    for (int k = 0; k < bound && q.size() > 0; k++) @(negedge clk);
    chk("drain_empty", 64'(q.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int  acc;
    int  gid;
    bit  got;
    bus.req_valid_in = '0;
    bus.req_addr_in  = '0;
    bus.req_wdata_in = '0;
    do_reset();

    // Closed bank, then row hit, then row conflict on bank 0.
    do_req(0, 1'b0, 3'd0, 8'd3, 4'd5, '0, acc);
    drain(100);
    chk("hit_after_miss", 64'(bus.hit_count_out), 64'd0);
    do_req(0, 1'b0, 3'd0, 8'd3, 4'd6, '0, acc);
    drain(100);
    chk("hit_after_hit", 64'(bus.hit_count_out), 64'd1);
    do_req(0, 1'b0, 3'd0, 8'd7, 4'd2, '0, acc);
    drain(100);
    chk("hit_after_conflict", 64'(bus.hit_count_out), 64'd1);

    // Write hit, then a new request offered the cycle after WR.
    do_req(0, 1'b1, 3'd0, 8'd7, 4'd9, 64'hDEADBEEF_CAFEF00D, acc);
    while (cyc < acc + 3) @(negedge clk);
    bus.req_valid_in[0] = 1'b1;
    bus.req_addr_in[0]  = build_addr(1'b0, 3'd0, 8'd7, 4'd1);
    #1;
    chk("ready_after_wr", 64'(bus.req_ready_out[0]), 64'd1);
    if (bus.req_ready_out[0]) push_req(0, 1'b0, 3'd0, 8'd7, 4'd1, '0, cyc);
    @(posedge clk);
    #1 bus.req_valid_in[0] = 1'b0;
    drain(100);
    chk("hit_after_wr", 64'(bus.hit_count_out), 64'(m_hits));
    chk("hit_count_3", 64'(bus.hit_count_out), 64'd3);

    // Both requesters continuously valid: grants alternate starting at 0.
    do_reset();
    @(negedge clk);
    bus.req_addr_in[0]  = build_addr(1'b0, 3'd1, 8'd2, 4'd1);
    bus.req_addr_in[1]  = build_addr(1'b1, 3'd2, 8'd5, 4'd3);
    bus.req_wdata_in[1] = 64'h1111_2222_3333_4444;
    bus.req_valid_in    = 2'b11;
    for (int g = 0; g < 4; g++) begin
      got = 1'b0;
      gid = 0;
      for (int k = 0; k < 200 && !got; k++) begin
        #1;
        if (|bus.req_ready_out) begin
          got = 1'b1;
          gid = bus.req_ready_out[1] ? 1 : 0;
          if (gid == 0) push_req(0, 1'b0, 3'd1, 8'd2, 4'd1, '0, cyc);
          else          push_req(1, 1'b1, 3'd2, 8'd5, 4'd3, 64'h1111_2222_3333_4444, cyc);
        end else begin
          @(negedge clk);
        end
      end
      chk("grant_seen_rr", 64'(got), 64'd1);
      chk("grant_order", 64'(gid), 64'(g % 2));
      @(posedge clk);
      if (g == 3) #1 bus.req_valid_in = '0;
      @(negedge clk);
    end
    drain(200);

    // Reset while waiting on CAS: no response, bank state forgotten.
    do_reset();
    do_req(1, 1'b0, 3'd3, 8'd9, 4'd4, '0, acc);
    void'(q.pop_back());
    while (cyc < acc + 15) @(negedge clk);
    chk("pre_reset_drain", 64'(q.size()), 64'd0);
    do_reset();
    repeat (40) @(negedge clk);
    chk("hit_after_abort", 64'(bus.hit_count_out), 64'd0);
    do_req(1, 1'b0, 3'd3, 8'd9, 4'd4, '0, acc);
    chk("abort_next_is_act", 64'(q[0].cmd), 64'd2);
    drain(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
